serial_logic_rx: RTL
====================

Name: serial_logic_rx

Overview:
- Receive end of the bit-serial operand link for the lab ALU datapath.
- Collects two WIDTH-bit operands A and B, delivered LSB first one bit pair per accepted cycle, and applies a bitwise logic operation (AND baseline).
- Presents the parallel result to the downstream register/display stage over a valid/ready handshake.
- Pairs with the serializer that shifts operands out of the operand registers.

Parameters:
- WIDTH, 4, operand/result width in bits; at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  serial bit pair valid.
- s_ready  output  1  receiver can accept a bit pair.
- s_first  input  1  marks bit 0 (LSB) of a new frame; qualified by s_valid.
- s_a  input  1  serial bit of operand A.
- s_b  input  1  serial bit of operand B.
- op  input  2  operation select; sampled on the s_first beat; see Optional Feature.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.
- res  output  WIDTH  bitwise result.
- busy  output  1  a frame is in progress or a result is held.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset: asynchronous active-low on rst_n; one clock domain (clk).
  - All outputs reset as follows: s_ready=1, res_valid=0, res=0, busy=0, frame_err=0.
  - State=IDLE, bit counter=0, operand shift registers=0.
- Beat: accepted when s_valid && s_ready on a rising clk edge.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE, beat with s_first=1: store s_a/s_b at bit 0, latch op, count=1, go SHIFT.
  - IDLE, beat with s_first=0: bits discarded, frame_err=1 next cycle, stay IDLE.
  - SHIFT, beat with s_first=0: store bits at index count, count+1.
  - SHIFT, beat with s_first=1: discard partial frame, frame_err=1, restart at bit 0, relatch op, count=1.
  - SHIFT, beat on bit WIDTH-1: compute result into res, res_valid=1 on the next cycle, go HOLD.
  - HOLD: s_ready=0; res and res_valid stable until res_valid && res_ready, then res_valid=0 and go IDLE.
- s_ready: 1 in IDLE and SHIFT, 0 in HOLD. Consequently no beat can be accepted on the same cycle the result handshake completes.
- busy: 1 in SHIFT and HOLD.
- Latency: res_valid asserts exactly one cycle after the WIDTH-th beat is accepted.
- Gaps: s_valid=0 cycles inside a frame are allowed; state and count are held, with no timeout.
- Counter: width clog2(WIDTH); never exceeds WIDTH-1 and never wraps silently.
- res: keeps its last value after handshake until the next result is written; it is not cleared.
- Reset mid-frame or mid-HOLD: immediate return to reset values; the partial frame or pending result is lost.
- frame_err: exactly one cycle per violation. Back-to-back violations give back-to-back pulses.

Optional Feature:
- Macro: SERIAL_LOGIC_OPS_EN.
- Defined: op selects 00=AND, 01=OR, 10=XOR, 11=NAND, applied bitwise to the full WIDTH word.
- Undefined: op port is present but ignored; the result is always A AND B. The port list is identical in both builds.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-SHIFT after 2 beats, release, then send a full frame A=4'b1011, B=4'b0110 with op=00 -> outputs at reset values during reset; after the frame, res=4'b0010 and res_valid=1 one cycle after the 4th beat.
- Back-pressure and handshake: same frame, res_ready held 0 for 5 cycles -> res_valid and res stable, s_ready=0, extra beats ignored; res_ready=1 -> next cycle res_valid=0, s_ready=1, busy=0.
- Gaps: insert 3 idle cycles between beats 2 and 3 -> same result 4'b0010, latency still one cycle after the last beat.
- Framing errors: beat with s_first=0 in IDLE -> frame_err pulse, state IDLE. Then beat with s_first=1 at bit 2 of a frame -> frame_err pulse, and the new frame A=4'b1111, B=4'b1010 yields res=4'b1010.
- Ops, with SERIAL_LOGIC_OPS_EN defined, A=4'b1011, B=4'b0110:
  - op=01 -> 4'b1111.
  - op=10 -> 4'b1101.
  - op=11 -> 4'b1101.
  - Without the macro, op=10 -> 4'b0010.
- Throughput: three consecutive frames with res_ready tied 1 -> each result seen exactly once, no beat accepted during HOLD cycles, no frame_err.

Source files
------------

// File: rtl/serial_logic_rx.sv
// rtl/serial_logic_rx.sv - bit-serial two-operand receiver with bitwise logic result
// Optional op decoding (OR/XOR/NAND) enabled by defining SERIAL_LOGIC_OPS_EN; default build is AND only.
module serial_logic_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_first,
    input  logic             s_a,
    input  logic             s_b,
    input  logic [1:0]       op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic             frame_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_full;
    logic [WIDTH-1:0] b_full;
    logic [WIDTH-1:0] res_nxt;
    logic             beat;
    logic             last_beat;

    assign s_ready   = (state != HOLD);
    assign busy      = (state != IDLE);
    assign res_valid = (state == HOLD);
    assign beat      = s_valid && s_ready;
    assign last_beat = (state == SHIFT) && !s_first && (count == CW'(WIDTH - 1));

    // Operands including the bit arriving this cycle, so the result is ready on the last beat.
    always_comb begin
        a_full        = a_q;
        b_full        = b_q;
        a_full[count] = s_a;
        b_full[count] = s_b;
    end

`ifdef SERIAL_LOGIC_OPS_EN
    logic [1:0] op_q;

    always_comb begin
        res_nxt = a_full & b_full;
        case (op_q)
            2'b00:   res_nxt = a_full & b_full;
            2'b01:   res_nxt = a_full | b_full;
            2'b10:   res_nxt = a_full ^ b_full;
            default: res_nxt = ~(a_full & b_full);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 2'b00;
        end else if (beat && s_first) begin
            op_q <= op;
        end
    end
`else
    logic unused_op;
    assign unused_op = ^op;
    assign res_nxt   = a_full & b_full;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat && s_first) state_nxt = SHIFT;
            SHIFT:   if (beat && last_beat) state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (beat) begin
                if (s_first) begin
                    // A new frame start always wins; a partial frame is dropped and flagged.
                    frame_err <= (state == SHIFT);
                    a_q[0]    <= s_a;
                    b_q[0]    <= s_b;
                    count     <= CW'(1);
                end else if (state == IDLE) begin
                    frame_err <= 1'b1;
                end else if (last_beat) begin
                    a_q   <= a_full;
                    b_q   <= b_full;
                    res   <= res_nxt;
                    count <= '0;
                end else begin
                    a_q   <= a_full;
                    b_q   <= b_full;
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule
